// File: rtl/prnd_pkg.sv
// prnd_pkg: shared constants and helpers for the pseudo-random bit packer
package prnd_pkg;
  localparam int DROP_CNT_W = 16;
  localparam int DEF_WORD_W = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/prnd_packer_if.sv
// prnd_packer_if: bit-stream input and packed-word output bundle of the packer
interface prnd_packer_if
  import prnd_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  logic flush;
  logic bit_i;
  logic bit_valid_i;
  logic [WORD_W-1:0] word_o;
  logic word_valid_o;
  logic word_ready_i;
  logic [level_w(FIFO_DEPTH)-1:0] level_o;
  logic [DROP_CNT_W-1:0] drop_count_o;
  modport master (
    output flush, bit_i, bit_valid_i, word_ready_i,
    input word_o, word_valid_o, level_o, drop_count_o
  );
  modport slave (
    input flush, bit_i, bit_valid_i, word_ready_i,
    output word_o, word_valid_o, level_o, drop_count_o
  );
endinterface

// File: rtl/prnd_fifo.sv
// prnd_fifo: registered word FIFO with wrap-bit pointers and synchronous clear
module prnd_fifo
  import prnd_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic full,
  output logic empty,
  output logic [level_w(DEPTH)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign level = wptr - rptr;
  assign data_out = mem[rptr[AW-1:0]];
  // pointers carry one extra wrap bit so equal low bits distinguish full from empty
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(push);
      rptr <= rptr + (AW+1)'(do_pop);
    end
  end
  // storage is cleared only by reset so the head reads zero out of reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wptr[AW-1:0]] <= data_in;
    end
  end
endmodule

// File: rtl/prnd_packer.sv
// prnd_packer: packs a serial LFSR bit stream LSB-first into words and buffers them
// Optional drop statistics counter enabled by defining PRND_PACKER_DROP_STATS_EN.
module prnd_packer
  import prnd_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic clock,
  input  logic reset_n,
  input  logic flush,
  input  logic bit_i,
  input  logic bit_valid_i,
  output logic [WORD_W-1:0] word_o,
  output logic word_valid_o,
  input  logic word_ready_i,
  output logic [level_w(FIFO_DEPTH)-1:0] level_o,
  output logic [DROP_CNT_W-1:0] drop_count_o
);
  localparam int CW = $clog2(WORD_W);
  logic [CW-1:0] bit_cnt;
  logic [WORD_W-1:0] partial, word;
  logic last, push, pop, full, empty;
  assign last = bit_valid_i && (bit_cnt == CW'(WORD_W - 1));
  assign pop = word_ready_i && !flush;
  // a full buffer still takes the new word when the head leaves on the same edge
  assign push = last && !flush && (!full || (word_ready_i && !empty));
  assign word = {bit_i, partial[WORD_W-2:0]};
  assign word_valid_o = !empty;
  // shift register and bit position of the word being assembled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      partial <= '0;
    end else if (flush) begin
      bit_cnt <= '0;
      partial <= '0;
    end else if (bit_valid_i) begin
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
      partial <= last ? '0 : partial | (WORD_W'(bit_i) << bit_cnt);
    end
  end
`ifdef PRND_PACKER_DROP_STATS_EN
  logic drop;
  assign drop = last && !flush && !push;
  // saturating count of completed words lost to a full buffer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) drop_count_o <= '0;
    else if (drop && drop_count_o != '1) drop_count_o <= drop_count_o + 1'b1;
  end
`else
  assign drop_count_o = '0;
`endif
  prnd_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .clear(flush),
    .push(push),
    .pop(pop),
    .data_in(word),
    .data_out(word_o),
    .full(full),
    .empty(empty),
    .level(level_o)
  );
endmodule

// File: tb/tb_prnd_packer.sv
// tb_prnd_packer: directed and random checks of prnd_packer against a queue model
module tb_prnd_packer;
  import prnd_pkg::*;
  localparam int W = 8;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int bits[$];
  int q[$];
  int exp_drop = 0;
  int saved[$];
  logic [W-1:0] w;

  prnd_packer_if #(.WORD_W(W), .FIFO_DEPTH(D)) bus ();

  prnd_packer #(.WORD_W(W), .FIFO_DEPTH(D)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush(bus.flush),
    .bit_i(bus.bit_i),
    .bit_valid_i(bus.bit_valid_i),
    .word_o(bus.word_o),
    .word_valid_o(bus.word_valid_o),
    .word_ready_i(bus.word_ready_i),
    .level_o(bus.level_o),
    .drop_count_o(bus.drop_count_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("word_valid", 32'(bus.word_valid_o), 32'(q.size() != 0));
    check("level", 32'(bus.level_o), 32'(q.size()));
    check("drop_count", 32'(bus.drop_count_o), 32'(exp_drop));
    if (q.size() != 0) check("word", 32'(bus.word_o), 32'(q[0]));
  endtask

  task automatic model_edge(input logic f, input logic b, input logic v, input logic r);
    int acc;
    if (f) begin
      bits.delete();
      q.delete();
      return;
    end
    if (r && q.size() != 0) void'(q.pop_front());
    if (v) begin
      bits.push_back(int'(b));
      if (bits.size() == W) begin
        acc = 0;
        for (int i = 0; i < W; i++) acc += bits[i] * (1 << i);
        bits.delete();
        if (q.size() < D) q.push_back(acc);
`ifdef PRND_PACKER_DROP_STATS_EN
        else if (exp_drop < 16'hFFFF) exp_drop++;
`endif
      end
    end
  endtask

  task automatic step(input logic f, input logic b, input logic v, input logic r);
    bus.flush = f;
    bus.bit_i = b;
    bus.bit_valid_i = v;
    bus.word_ready_i = r;
    @(posedge clock);
    model_edge(f, b, v, r);
    #1;
    check_model();
  endtask

  task automatic send_word(input logic [W-1:0] x, input logic r);
    for (int i = 0; i < W; i++) step(1'b0, x[i], 1'b1, r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_word"}, 32'(bus.word_o), 32'h0);
    check({tag, "_valid"}, 32'(bus.word_valid_o), 32'h0);
    check({tag, "_level"}, 32'(bus.level_o), 32'h0);
    check({tag, "_drop"}, 32'(bus.drop_count_o), 32'h0);
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.bit_i = 1'b0;
    bus.bit_valid_i = 1'b0;
    bus.word_ready_i = 1'b0;
    #12;
    check_zero("por");
    @(negedge clock);
    reset_n = 1'b1;
    // reset mid-stream with a word buffered and a partial word pending
    send_word(8'hC3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    bits.delete();
    q.delete();
    exp_drop = 0;
    #1;
    check_zero("mid_reset");
    @(negedge clock);
    reset_n = 1'b1;
    send_word(8'h01, 1'b0);
    check("reset_word", 32'(bus.word_o), 32'h01);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // ordering with the consumer always ready
    send_word(8'h5A, 1'b1);
    check("order_first", 32'(bus.word_o), 32'h5A);
    send_word(8'h0F, 1'b1);
    check("order_second", 32'(bus.word_o), 32'h0F);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("order_drained", 32'(bus.level_o), 32'h0);
    // gapped input: one valid bit every third cycle, junk on bit_i in between
    w = 8'h5A;
    for (int i = 0; i < W; i++) begin
      step(1'b0, w[i], 1'b1, 1'b0);
      step(1'b0, 1'($urandom), 1'b0, 1'b0);
      step(1'b0, 1'($urandom), 1'b0, 1'b0);
    end
    check("gapped_word", 32'(bus.word_o), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // overflow: five words into a four-deep buffer with no consumer
    saved.delete();
    for (int k = 0; k < 5; k++) begin
      w = 8'($urandom);
      saved.push_back(int'(w));
      send_word(w, 1'b0);
    end
    check("ovf_level", 32'(bus.level_o), 32'(D));
`ifdef PRND_PACKER_DROP_STATS_EN
    check("ovf_drop", 32'(bus.drop_count_o), 32'h1);
`else
    check("ovf_drop", 32'(bus.drop_count_o), 32'h0);
`endif
    for (int k = 0; k < D; k++) begin
      check("ovf_drain", 32'(bus.word_o), 32'(saved[k]));
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check("ovf_empty", 32'(bus.word_valid_o), 32'h0);
    // full buffer, word completes while the head is popped
    saved.delete();
    for (int k = 0; k < 5; k++) saved.push_back(int'($urandom_range(255)));
    for (int k = 0; k < D; k++) send_word(8'(saved[k]), 1'b0);
    w = 8'(saved[4]);
    for (int i = 0; i < W - 1; i++) step(1'b0, w[i], 1'b1, 1'b0);
    step(1'b0, w[W-1], 1'b1, 1'b1);
    check("fpp_level", 32'(bus.level_o), 32'(D));
    for (int k = 1; k < 5; k++) begin
      check("fpp_drain", 32'(bus.word_o), 32'(saved[k]));
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    // flush with two words buffered and three bits pending; bit and pop ignored
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("flush_level", 32'(bus.level_o), 32'h0);
    check("flush_valid", 32'(bus.word_valid_o), 32'h0);
    send_word(8'h96, 1'b0);
    check("flush_fresh", 32'(bus.word_o), 32'h96);
    // random traffic against the model
    for (int n = 0; n < 600; n++)
      step(1'($urandom_range(31) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prnd_packer.md
PRND_PACKER -- requirements
Module: prnd_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 8: packed word width, legal range 2..32.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output word buffer depth, power of two, legal range 2..16.
REQ-003 SHALL have port clock, input, 1 bit: sole clock, all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous clear of the partial word and the buffer.
REQ-006 SHALL have port bit_i, input, 1 bit: serial pseudo-random bit from the LFSR stage (prnd_o).
REQ-007 SHALL have port bit_valid_i, input, 1 bit: bit_i is taken this cycle; there is no backpressure to the LFSR.
REQ-008 SHALL have port word_o, output, WORD_W bits: head-of-buffer packed word.
REQ-009 SHALL have port word_valid_o, output, 1 bit: buffer is not empty.
REQ-010 SHALL have port word_ready_i, input, 1 bit: consumer accepts word_o when it is high together with word_valid_o.
REQ-011 SHALL have port level_o, output, $clog2(FIFO_DEPTH)+1 bits: buffered word count.
REQ-012 SHALL have port drop_count_o, output, 16 bits: count of discarded words (see Configuration).

Function
REQ-013 SHALL shift each accepted bit into the partial word LSB-first, so the first bit of a word lands in word bit 0.
REQ-014 SHALL keep a bit counter, range 0..WORD_W-1, that increments on each accepted bit and wraps to 0 on the bit that completes a word.
REQ-015 SHALL push the completed word into the buffer on the same edge that accepts its final bit, with word_valid_o high on the next cycle (1-cycle latency from final bit to output).
REQ-016 SHALL treat the buffer as FIFO ordered, with word_o driven from registered storage and no combinational path from bit_i.
REQ-017 SHALL pop one word on each cycle where word_valid_o and word_ready_i are both high.
REQ-018 SHALL, when the buffer is full and a word completes without a pop in the same cycle, discard the new word, leave buffered contents unchanged, and reset the bit counter normally.
REQ-019 SHALL, when the buffer is full and a word completes with a pop in the same cycle, accept the push; the level stays FIFO_DEPTH.
REQ-020 SHALL, on a simultaneous push and pop with any other level, leave level_o unchanged.
REQ-021 SHALL ignore word_ready_i while the buffer is empty.
REQ-022 SHALL, when flush is high, clear the bit counter, partial word and buffer on that edge, ignore any bit or pop in that cycle, and leave drop_count_o unchanged.
REQ-023 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH, using one extra pointer bit for full/empty detection.

Reset
REQ-024 SHALL, while reset_n is low, asynchronously force: bit counter 0, partial word 0, buffer empty, word_valid_o 0, word_o 0, level_o 0, drop_count_o 0.
REQ-025 SHALL discard any partially packed word lost to reset mid-word; packing SHALL restart at bit 0 on the first accepted bit after release.

Configuration
REQ-026 SHALL use macro PRND_PACKER_DROP_STATS_EN.
REQ-027 SHALL, when the macro is defined, increment drop_count_o on every discarded word (REQ-018) and saturate it at 16'hFFFF.
REQ-028 SHALL, when the macro is undefined, tie drop_count_o to 0 and omit the counter logic; the port list SHALL be identical in both builds.

Structure
REQ-029 SHALL place in shared package prnd_pkg: the DROP_CNT_W=16 constant, the default WORD_W/FIFO_DEPTH constants, and a function returning the level width.
REQ-030 SHALL implement the buffer as sub-module prnd_fifo (push, pop, data, full, empty, level); the packer and counter SHALL stay in prnd_packer.

Verification
REQ-031 SHALL include scenario reset: reset_n low mid-stream -> all outputs 0; after release, 8 bits 1,0,0,0,0,0,0,0 -> word_o=8'h01 one cycle after the 8th bit.
REQ-032 SHALL include scenario ordering: bits 0,1,0,1,1,0,1,0 then 1,1,1,1,0,0,0,0 with ready high -> words 8'h5A then 8'h0F, in order.
REQ-033 SHALL include scenario gapped input: bit_valid_i asserted every third cycle -> same word values as the contiguous stream, counter holds between bits.
REQ-034 SHALL include scenario overflow: ready low, 5 words at FIFO_DEPTH=4 -> level_o=4, 5th word dropped, drop_count_o=1 (macro defined) or 0 (undefined); drain yields the first 4 words.
REQ-035 SHALL include scenario full push+pop: level 4, word completes while ready high -> level_o stays 4, no drop, new word at tail.
REQ-036 SHALL include scenario flush: flush after 3 bits of a word with 2 words buffered -> level_o=0, word_valid_o=0; the next 8 bits form a complete fresh word.
